// File: rtl/fastram_cycle_ctrl_pkg.sv
// Shared types and constants for the fast-RAM bus cycle sequencer.
package fastram_cycle_ctrl_pkg;

  // Width of the wait-state counter (WAIT_STATES range 0..7)
  localparam int WS_W = 3;

  // Bus cycle sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_WSTRB  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ACK    = 3'd4,
    ST_HOLD   = 3'd5
  } state_e;

  // Registered pin bundle; SRAM enables are active-low, the rest active-high
  typedef struct packed {
    logic ram_ce;
    logic ram_oe;
    logic ram_we;
    logic ram_ub;
    logic ram_lb;
    logic data_oe;
    logic dtack;
    logic busy;
  } bus_out_t;

  localparam bus_out_t BUS_OUT_IDLE = '{
    ram_ce:  1'b1,
    ram_oe:  1'b1,
    ram_we:  1'b1,
    ram_ub:  1'b1,
    ram_lb:  1'b1,
    data_oe: 1'b0,
    dtack:   1'b0,
    busy:    1'b0
  };

  // True when at least one (active-low) data strobe is asserted
  function automatic logic strobe_any(input logic uds_n, input logic lds_n);
    return ~(uds_n & lds_n);
  endfunction

endpackage

// File: rtl/fastram_cycle_ctrl_bus_sync.sv
// Multi-stage flop chain bringing asynchronous CPU bus strobes into the CLK domain.
module fastram_cycle_ctrl_bus_sync #(
  parameter int               WIDTH   = 4,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain_r [STAGES];

  // Shift the asynchronous inputs through the synchronizer chain
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < STAGES; i++) begin
        chain_r[i] <= RST_VAL;
      end
    end else begin
      chain_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain_r[i] <= chain_r[i-1];
      end
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/fastram_cycle_ctrl.sv
// Sequences 68000 bus cycles onto the on-board fast-RAM SRAM: address decode
// against the autoconfig base, SRAM enables, and DTACK after programmable waits.
import fastram_cycle_ctrl_pkg::*;

module fastram_cycle_ctrl #(
  parameter int WAIT_STATES = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       _AS,
  input  logic       _UDS,
  input  logic       _LDS,
  input  logic       RW,
  input  logic [2:0] AH,
  input  logic [2:0] base_address,
  input  logic       configured,
  output logic       _RAM_CE,
  output logic       _RAM_OE,
  output logic       _RAM_WE,
  output logic       _RAM_UB,
  output logic       _RAM_LB,
  output logic       data_oe,
  output logic       DTACK,
  output logic       busy
);

  localparam logic [WS_W-1:0] WS_LOAD = WS_W'(WAIT_STATES);

  logic [3:0]      sync_q_s;
  logic            as_s;
  logic            uds_s;
  logic            lds_s;
  logic            rw_s;
  logic            hit_s;
  logic            access_done_s;
  state_e          state_r;
  state_e          state_nxt_s;
  logic [WS_W-1:0] cnt_r;
  logic            write_r;
  logic            write_nxt_s;
  bus_out_t        out_r;
  bus_out_t        out_nxt_s;

  fastram_cycle_ctrl_bus_sync #(
    .WIDTH   (4),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (4'b1111)
  ) u_bus_sync (
    .CLK (CLK),
    .RST (RST),
    .d   ({_AS, _UDS, _LDS, RW}),
    .q   (sync_q_s)
  );

  // as_s is the asserted (active-high) address strobe; data strobes stay active-low
  assign as_s          = ~sync_q_s[3];
  assign uds_s         = sync_q_s[2];
  assign lds_s         = sync_q_s[1];
  assign rw_s          = sync_q_s[0];
  assign hit_s         = configured & (AH == base_address);
  // Leaving ACCESS on the same edge the counter reaches zero
  assign access_done_s = (cnt_r <= 3'd1);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a dropped address strobe ends any cycle immediately
  always_comb begin
    state_nxt_s = state_r;
    write_nxt_s = write_r;
    case (state_r)
      ST_IDLE: begin
        write_nxt_s = 1'b0;
        if (as_s && hit_s) begin
          state_nxt_s = ST_SETUP;
        end else if (as_s) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        write_nxt_s = ~rw_s;
        if (!as_s) begin
          state_nxt_s = ST_IDLE;
        end else if (rw_s) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_WSTRB;
        end
      end
      ST_WSTRB: begin
        if (!as_s) begin
          state_nxt_s = ST_IDLE;
        end else if (strobe_any(uds_s, lds_s)) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_WSTRB;
        end
      end
      ST_ACCESS: begin
        if (!as_s) begin
          state_nxt_s = ST_IDLE;
        end else if (access_done_s) begin
          state_nxt_s = ST_ACK;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_ACK: begin
        // TAS: after the read half, RW low with strobes released starts the write half
        if (!as_s) begin
          state_nxt_s = ST_IDLE;
        end else if (!write_r && !rw_s && !strobe_any(uds_s, lds_s)) begin
          state_nxt_s = ST_WSTRB;
          write_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_ACK;
        end
      end
      ST_HOLD: begin
        if (!as_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        write_nxt_s = 1'b0;
      end
    endcase
  end

  // Output decode from the upcoming state so pins change together with the state
  always_comb begin
    out_nxt_s = BUS_OUT_IDLE;
    case (state_nxt_s)
      ST_IDLE: begin
        out_nxt_s = BUS_OUT_IDLE;
      end
      ST_HOLD: begin
        out_nxt_s.busy = 1'b1;
      end
      ST_SETUP, ST_WSTRB: begin
        out_nxt_s.ram_ce = 1'b0;
        out_nxt_s.busy   = 1'b1;
      end
      ST_ACCESS, ST_ACK: begin
        out_nxt_s.ram_ce = 1'b0;
        out_nxt_s.busy   = 1'b1;
        out_nxt_s.ram_ub = uds_s;
        out_nxt_s.ram_lb = lds_s;
        out_nxt_s.dtack  = (state_nxt_s == ST_ACK);
        if (write_nxt_s) begin
          out_nxt_s.ram_we = 1'b0;
        end else begin
          out_nxt_s.ram_oe  = 1'b0;
          out_nxt_s.data_oe = 1'b1;
        end
      end
      default: begin
        out_nxt_s = BUS_OUT_IDLE;
      end
    endcase
  end

  // Output, transfer-direction and wait-counter registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_r   <= BUS_OUT_IDLE;
      write_r <= 1'b0;
      cnt_r   <= 3'd0;
    end else begin
      out_r   <= out_nxt_s;
      write_r <= write_nxt_s;
      if ((state_r != ST_ACCESS) && (state_nxt_s == ST_ACCESS)) begin
        cnt_r <= WS_LOAD;
      end else if ((state_r == ST_ACCESS) && (cnt_r != 3'd0)) begin
        cnt_r <= cnt_r - 3'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign _RAM_CE = out_r.ram_ce;
  assign _RAM_OE = out_r.ram_oe;
  assign _RAM_WE = out_r.ram_we;
  assign _RAM_UB = out_r.ram_ub;
  assign _RAM_LB = out_r.ram_lb;
  assign data_oe = out_r.data_oe;
  assign DTACK   = out_r.dtack;
  assign busy    = out_r.busy;

endmodule

// File: tb/tb_fastram_cycle_ctrl.sv
// Randomized bench for fastram_cycle_ctrl. Each bus cycle is described by the
// slot in which every CPU pin changes; the expected pin state at every clock
// edge is derived arithmetically from those slots (synchronizer delay, wait
// states, strobe timing) rather than by stepping a state machine.
module tb_fastram_cycle_ctrl;

  localparam int WS = 1;
  localparam int SS = 2;
  localparam int WM = (WS < 1) ? 1 : WS;

  localparam int PH_IDLE  = 0;
  localparam int PH_HOLD  = 1;
  localparam int PH_ADDR  = 2;
  localparam int PH_RD    = 3;
  localparam int PH_RDACK = 4;
  localparam int PH_WR    = 5;
  localparam int PH_WRACK = 6;

  localparam int K_RD  = 0;
  localparam int K_WR  = 1;
  localparam int K_TAS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw = 1'b1;
  logic [2:0] ah = 3'b001, base = 3'b001;
  logic       configured = 1'b1;
  logic       ram_ce, ram_oe, ram_we, ram_ub, ram_lb, data_oe, dtack, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int txn_id   = 0;

  logic as_h [0:63];
  logic uds_h[0:63];
  logic lds_h[0:63];
  logic rw_h [0:63];

  always #5 clk = ~clk;

  fastram_cycle_ctrl #(.WAIT_STATES(WS), .SYNC_STAGES(SS)) dut (
    .CLK          (clk),
    .RST          (rst),
    ._AS          (as_n),
    ._UDS         (uds_n),
    ._LDS         (lds_n),
    .RW           (rw),
    .AH           (ah),
    .base_address (base),
    .configured   (configured),
    ._RAM_CE      (ram_ce),
    ._RAM_OE      (ram_oe),
    ._RAM_WE      (ram_we),
    ._RAM_UB      (ram_ub),
    ._RAM_LB      (ram_lb),
    .data_oe      (data_oe),
    .DTACK        (dtack),
    .busy         (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected pins {ce,oe,we,ub,lb,data_oe,dtack,busy} for a bus phase
  function automatic logic [7:0] exp_pins(input int ph, input logic ub, input logic lb);
    case (ph)
      PH_HOLD:  return 8'b1111_1001;
      PH_ADDR:  return 8'b0111_1001;
      PH_RD:    return {3'b001, ub, lb, 3'b101};
      PH_RDACK: return {3'b001, ub, lb, 3'b111};
      PH_WR:    return {3'b010, ub, lb, 3'b001};
      PH_WRACK: return {3'b010, ub, lb, 3'b011};
      default:  return 8'b1111_1000;
    endcase
  endfunction

  // One CPU bus cycle. strb = {_UDS,_LDS} levels while asserted.
  // RD/WR: r_arg = slot in which _AS is released. TAS: p_off/d2 shape the
  // write half and r_arg is extra ACK length. rst_at >= 0 pulses RST (with
  // _AS released) in that slot.
  task automatic run_txn(input int kind, input logic [1:0] strb, input int d_wr,
                         input int p_off, input int d2, input int r_arg, input int rst_at,
                         input logic [2:0] ah_v, input logic cfg_v,
                         input logic ah_twist, input logic cfg_drop);
    int   k1, p, q, w1, a2, a, r, n, idle_from, ph, idx;
    logic hit, ub_e, lb_e;
    logic [7:0] obs;
    txn_id++;
    hit = cfg_v & (ah_v == base);
    k1  = SS + 2 + WM;
    p   = k1 + p_off;
    q   = p + 1 + d2;
    w1  = p + SS + 2;
    a2  = q + SS + 1;
    a   = (d_wr + SS + 1 > SS + 3) ? d_wr + SS + 1 : SS + 3;
    r   = (kind == K_TAS) ? a2 + WM - SS + r_arg : r_arg;
    if (rst_at >= 0 && rst_at < r) r = rst_at;
    idle_from = r + SS + 1;
    if (rst_at >= 0 && rst_at + 1 < idle_from) idle_from = rst_at + 1;
    n = r + SS + 4;
    for (int k = 0; k < 64; k++) begin
      as_h[k]  = (k < r) ? 1'b0 : 1'b1;
      uds_h[k] = 1'b1;
      lds_h[k] = 1'b1;
      rw_h[k]  = 1'b1;
      if (k < r) begin
        if (kind == K_RD) begin
          {uds_h[k], lds_h[k]} = strb;
        end else if (kind == K_WR) begin
          rw_h[k] = 1'b0;
          if (k >= d_wr) {uds_h[k], lds_h[k]} = strb;
        end else begin
          if (k < p || k >= q) {uds_h[k], lds_h[k]} = strb;
          if (k >= p + 1) rw_h[k] = 1'b0;
        end
      end
    end
    for (int e = 0; e <= n; e++) begin
      @(negedge clk);
      // expected phase after edge e of this cycle
      if (e <= SS) ph = PH_IDLE;
      else if (!hit) ph = PH_HOLD;
      else if (e == SS + 1) ph = PH_ADDR;
      else if (kind == K_RD) ph = (e < k1) ? PH_RD : PH_RDACK;
      else if (kind == K_WR) ph = (e < a) ? PH_ADDR : (e < a + WM) ? PH_WR : PH_WRACK;
      else if (e < k1) ph = PH_RD;
      else if (e < w1) ph = PH_RDACK;
      else if (e < a2) ph = PH_ADDR;
      else if (e < a2 + WM) ph = PH_WR;
      else ph = PH_WRACK;
      if (e >= idle_from) ph = PH_IDLE;
      idx  = e - 1 - SS;
      ub_e = (idx >= 0) ? uds_h[idx] : 1'b1;
      lb_e = (idx >= 0) ? lds_h[idx] : 1'b1;
      obs  = {ram_ce, ram_oe, ram_we, ram_ub, ram_lb, data_oe, dtack, busy};
      check_eq($sformatf("pins t%0d k%0d e%0d ph%0d", txn_id, kind, e, ph), {24'd0, obs},
               {24'd0, exp_pins(ph, ub_e, lb_e)});
      check_eq($sformatf("oe_we_excl t%0d e%0d", txn_id, e), {31'd0, ~ram_oe & ~ram_we}, 32'd0);
      if (e < n) begin
        as_n  = as_h[e];
        uds_n = uds_h[e];
        lds_n = lds_h[e];
        rw    = rw_h[e];
        rst   = (e == rst_at);
        if (e == 0) begin
          ah         = ah_v;
          configured = cfg_v;
        end
        if (ah_twist && e >= SS + 2) ah = 3'($urandom);
        if (cfg_drop && e >= SS + 2) configured = 1'b0;
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, including RST held against a live matching bus cycle
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_idle", {24'd0, ram_ce, ram_oe, ram_we, ram_ub, ram_lb, data_oe, dtack, busy},
             {24'd0, 8'b1111_1000});
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq($sformatf("reset_wins c%0d", i),
               {24'd0, ram_ce, ram_oe, ram_we, ram_ub, ram_lb, data_oe, dtack, busy},
               {24'd0, 8'b1111_1000});
    end
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Directed cycles
    run_txn(K_RD,  2'b00, 0, 0, 1, 7, -1, 3'b001, 1'b1, 1'b0, 1'b0); // word read, DTACK at edge 5
    run_txn(K_WR,  2'b10, 2, 0, 1, 9, -1, 3'b001, 1'b1, 1'b0, 1'b0); // late low-byte write
    run_txn(K_RD,  2'b00, 0, 0, 1, 6, -1, 3'b010, 1'b1, 1'b0, 1'b0); // foreign address
    run_txn(K_RD,  2'b00, 0, 0, 1, 6, -1, 3'b001, 1'b0, 1'b0, 1'b0); // not configured
    run_txn(K_RD,  2'b01, 0, 0, 1, 7, -1, 3'b001, 1'b1, 1'b0, 1'b0); // configured again
    run_txn(K_RD,  2'b00, 0, 0, 1, 2, -1, 3'b001, 1'b1, 1'b0, 1'b0); // abort in ACCESS
    run_txn(K_RD,  2'b00, 0, 0, 1, 9,  6, 3'b001, 1'b1, 1'b0, 1'b0); // RST during ACK
    run_txn(K_RD,  2'b00, 0, 0, 1, 6, -1, 3'b001, 1'b1, 1'b1, 1'b1); // AH/configured move mid-cycle
    run_txn(K_RD,  2'b00, 0, 0, 1, 6, -1, 3'b001, 1'b1, 1'b0, 1'b0); // served after that
    run_txn(K_TAS, 2'b00, 0, 1, 1, 1, -1, 3'b001, 1'b1, 1'b0, 1'b0); // read-modify-write

    // Randomized cycles
    for (int t = 0; t < 60; t++) begin
      int         kind, dw, po, dd, ra, rs;
      logic [1:0] st;
      logic [2:0] av;
      if ($urandom_range(0, 9) == 0) base = 3'($urandom);
      kind = $urandom_range(0, 2);
      st   = 2'($urandom_range(0, 2));
      dw   = $urandom_range(0, 4);
      po   = $urandom_range(0, 2);
      dd   = $urandom_range(1, 2);
      ra   = (kind == K_TAS) ? $urandom_range(0, 2) : $urandom_range(1, 10);
      rs   = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 8) : -1;
      av   = ($urandom_range(0, 9) < 7) ? base : 3'($urandom);
      run_txn(kind, st, dw, po, dd, ra, rs, av, ($urandom_range(0, 9) != 0),
              1'($urandom), ($urandom_range(0, 4) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
